// File: rtl/clkgen_div_multi.sv
// clkgen_div_multi: multi-channel programmable clock divider with phase alignment and lock detect
// Optional CLKGEN_GLITCH_GATE_EN holds outclk/outclk_en low until locked.
module clkgen_div_multi #(
    parameter int NUM_CLOCKS  = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_chan,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_phase,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic                  locked
);
    localparam logic [1:0] ALIGN  = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam int SW = $clog2(LOCK_CYCLES + 1);
    localparam logic [SW-1:0] LAST = SW'(LOCK_CYCLES - 1);
    logic [1:0]    state, state_nxt;
    logic [SW-1:0] settle_cnt;
    logic          accept, restart, active;
    assign cfg_ready = !rst && state != ALIGN;
    assign accept    = cfg_valid && cfg_ready;
    assign restart   = accept && (32'(cfg_chan) < NUM_CLOCKS);
    always_comb
        state_nxt = (rst || restart) ? ALIGN :
                    (state == ALIGN) ? SETTLE :
                    (state == LOCKED || (state == SETTLE && settle_cnt == LAST)) ? LOCKED :
                    (state == SETTLE) ? SETTLE : ALIGN;
    // outputs are registered from next-cycle state so they line up with locked
`ifdef CLKGEN_GLITCH_GATE_EN
    assign active = state_nxt == LOCKED;
`else
    assign active = state_nxt != ALIGN;
`endif
    always_ff @(posedge refclk) begin
        state      <= state_nxt;
        settle_cnt <= (state == SETTLE && !rst) ? settle_cnt + SW'(1) : '0;
        locked     <= state_nxt == LOCKED;
    end
    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : ch
        logic [DIV_W-1:0] div_q, phase_q, cnt, cnt_nxt, n, start;
        logic [DIV_W:0]   half;
        logic             oc_q, en_q;
        assign n       = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
        assign start   = (phase_q < n) ? phase_q : '0;
        assign half    = ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
        assign cnt_nxt = (state == ALIGN) ? start : (cnt >= n - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        always_ff @(posedge refclk) begin
            if (rst) begin
                div_q   <= DIV_W'(DEFAULT_DIV);
                phase_q <= '0;
                cnt     <= '0;
                oc_q    <= 1'b0;
                en_q    <= 1'b0;
            end else begin
                if (accept && cfg_chan == 3'(g)) begin
                    div_q   <= cfg_div;
                    phase_q <= cfg_phase;
                end
                cnt  <= cnt_nxt;
                oc_q <= active && ({1'b0, cnt_nxt} < half);
                en_q <= active && cnt_nxt == '0;
            end
        end
        assign outclk[g]    = oc_q;
        assign outclk_en[g] = en_q;
    end
endmodule

// File: tb/tb_clkgen_div_multi.sv
// tb_clkgen_div_multi: directed + random stimulus against a cycles-since-restart reference model
module tb_clkgen_div_multi;
    localparam int NC = 4;
    localparam int DW = 16;
    localparam int LC = 16;
`ifdef CLKGEN_GLITCH_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif
    logic          refclk = 1'b0;
    logic          rst = 1'b1, cfg_valid = 1'b0, cfg_ready;
    logic [2:0]    cfg_chan = '0;
    logic [DW-1:0] cfg_div = '0, cfg_phase = '0;
    logic [NC-1:0] outclk, outclk_en;
    logic          locked;
    int            n_chk = 0, n_fail = 0;
    int            k = 0;
    int            mdiv [NC];
    int            mphase [NC];

    clkgen_div_multi #(.NUM_CLOCKS(NC), .DIV_W(DW), .LOCK_CYCLES(LC), .DEFAULT_DIV(2)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // k counts edges since the last reset edge or accepted restart; k==0 is the align cycle
    task automatic check_all();
        logic [NC-1:0] e_oc, e_en;
        bit            e_lock, run;
        int            n, s, c;
        e_lock = k >= LC + 1;
        run    = GATE ? e_lock : (k >= 1);
        for (int i = 0; i < NC; i++) begin
            n = (mdiv[i] < 2) ? 2 : mdiv[i];
            s = (mphase[i] < n) ? mphase[i] : 0;
            c = (k >= 1) ? (s + k - 1) % n : 0;
            e_oc[i] = run && (c < (n + 1) / 2);
            e_en[i] = run && (c == 0);
        end
        chk("cfg_ready", 32'(cfg_ready), 32'(!rst && k >= 1));
        chk("locked", 32'(locked), 32'(e_lock));
        chk("outclk", 32'(outclk), 32'(e_oc));
        chk("outclk_en", 32'(outclk_en), 32'(e_en));
    endtask

    task automatic cyc(input bit r, input bit v, input int ch, input int d, input int p);
        bit acc;
        rst       = r;
        cfg_valid = v;
        cfg_chan  = 3'(ch);
        cfg_div   = DW'(d);
        cfg_phase = DW'(p);
        acc = v && !r && k >= 1;
        @(posedge refclk);
        if (r) begin
            k = 0;
            for (int i = 0; i < NC; i++) begin
                mdiv[i]   = 2;
                mphase[i] = 0;
            end
        end else if (acc && ch < NC) begin
            mdiv[ch]   = d;
            mphase[ch] = p;
            k = 0;
        end else begin
            k++;
        end
        @(negedge refclk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            mdiv[i]   = 2;
            mphase[i] = 0;
        end
        for (int i = 0; i < 3; i++) cyc(1, i == 1, 1, 7, 0);
        idle(20);
        cyc(0, 1, 1, 5, 0);
        idle(25);
        cyc(0, 1, 2, 4, 2);
        idle(25);
        cyc(0, 1, 3, 0, 0);
        idle(20);
        cyc(0, 1, 6, 9, 1);
        idle(5);
        cyc(0, 1, 0, 3, 0);
        idle(10);
        cyc(0, 1, 1, 7, 3);
        idle(20);
        cyc(0, 1, 2, 6, 9);
        idle(20);
        cyc(1, 0, 0, 0, 0);
        idle(20);
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = ($urandom % 8 == 0) ? int'($urandom % 65536) : int'($urandom % 10);
            cyc($urandom % 300 == 0, $urandom % 25 == 0, int'($urandom % 8), d, int'($urandom % 12));
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
